gmii_tx_framer: RTL

- Egress stage directly downstream of the port forwarder.
- Drains one port's 9-bit tx FIFO (bits 7:0 data byte, bit 8 end-of-frame) and drives a GMII transmit interface.
- Prepends preamble and SFD, enforces the inter-frame gap, and aborts frames on FIFO underrun with tx_er.
- The FCS is carried in the FIFO stream and is passed through untouched; one instance per port.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/tx_stat_counters.sv | 33 +++
 rtl/gmii_tx_framer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit framer state type.
// Used by the GMII egress stage of every switch port.
package eth_pkg;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
    localparam int         FIFO_EOF_BIT      = 8;
    localparam int         FIFO_WORD_W       = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_IFG      = 3'd5
    } tx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_stat_counters.sv
// Per-port transmit statistics: wrapping good-frame count and
// saturating underrun count.
module tx_stat_counters (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_frame_inc,
    input  logic        i_underrun_inc,
    output logic [31:0] o_frames,
    output logic [15:0] o_underrun
);

    logic [31:0] r_frames;
    logic [15:0] r_underrun;

    // Underrun count sticks at all-ones so a flood of aborts stays visible.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_frames   <= 32'd0;
            r_underrun <= 16'd0;
        end else begin
            if (i_frame_inc) begin
                r_frames <= r_frames + 32'd1;
            end
            if (i_underrun_inc && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end

    assign o_frames   = r_frames;
    assign o_underrun = r_underrun;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: drains a 9-bit tx FIFO, adds preamble/SFD,
// enforces the inter-frame gap and aborts underrun frames with tx_er.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [FIFO_WORD_W-1:0] tx_dout,
    input  logic                   tx_empty,
    output logic                   tx_rd_en,
    output logic [7:0]             gmii_txd,
    output logic                   gmii_tx_en,
    output logic                   gmii_tx_er,
    output logic [31:0]            stat_tx_frames,
    output logic [15:0]            stat_tx_underrun
);

    localparam int CNT_MAX = max_int(PREAMBLE_LEN, IFG_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] IFG_LOAD = CNT_W'(IFG_CYCLES - 1);

    tx_state_t        r_state;
    tx_state_t        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_byte_valid;

    logic [7:0]       w_next_txd;
    logic             w_next_en;
    logic             w_next_er;
    logic             w_fetch_window;
    logic             w_drain_rd;
    logic             w_eof_seen;
    logic             w_frame_inc;
    logic             w_underrun_inc;

    assign w_eof_seen = r_byte_valid & tx_dout[FIFO_EOF_BIT];
    assign tx_rd_en   = (w_fetch_window | w_drain_rd) & ~tx_empty & ~w_eof_seen;

    // The GMII registers are loaded with the byte for the next wire cycle,
    // so the FIFO word present now becomes the wire byte one cycle later.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_txd     = 8'h00;
        w_next_en      = 1'b0;
        w_next_er      = 1'b0;
        w_fetch_window = 1'b0;
        w_drain_rd     = 1'b0;
        w_frame_inc    = 1'b0;
        w_underrun_inc = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    w_next_state = ST_PREAMBLE;
                    w_next_cnt   = PRE_LOAD;
                    w_next_txd   = ETH_PREAMBLE_BYTE;
                    w_next_en    = 1'b1;
                end
            end

            ST_PREAMBLE: begin
                w_next_en = 1'b1;
                if (r_cnt == '0) begin
                    w_fetch_window = 1'b1;
                    w_next_state   = ST_SFD;
                    w_next_txd     = ETH_SFD_BYTE;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                    w_next_txd = ETH_PREAMBLE_BYTE;
                end
            end

            // A missing byte here means the FIFO ran dry mid-frame.
            ST_SFD, ST_DATA: begin
                w_fetch_window = 1'b1;
                w_next_state   = ST_DATA;
                w_next_en      = 1'b1;
                if (r_byte_valid) begin
                    w_next_txd = tx_dout[7:0];
                    if (tx_dout[FIFO_EOF_BIT]) begin
                        w_frame_inc  = 1'b1;
                        w_next_state = ST_IFG;
                        w_next_cnt   = IFG_LOAD;
                    end
                end else begin
                    w_next_er      = 1'b1;
                    w_underrun_inc = 1'b1;
                    w_next_state   = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                w_drain_rd = 1'b1;
                if (w_eof_seen) begin
                    w_next_state = ST_IFG;
                    w_next_cnt   = IFG_LOAD;
                end
            end

            ST_IFG: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_byte_valid <= 1'b0;
            gmii_txd     <= 8'h00;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_byte_valid <= tx_rd_en;
            gmii_txd     <= w_next_txd;
            gmii_tx_en   <= w_next_en;
            gmii_tx_er   <= w_next_er;
        end
    end

    tx_stat_counters u_stats (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .i_frame_inc    (w_frame_inc),
        .i_underrun_inc (w_underrun_inc),
        .o_frames       (stat_tx_frames),
        .o_underrun     (stat_tx_underrun)
    );

endmodule
